// File: rtl/keypad_time_entry.sv
// keypad_time_entry: 4x4 matrix keypad scanner with frame-based debounce
// feeding an HH:MM:SS entry buffer that commits to a seconds count on '#'.
module keypad_time_entry #(
  parameter int SCAN_DIV  = 100000,
  parameter int DEB_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  h1,
  output logic [3:0]  h2,
  output logic [3:0]  m1,
  output logic [3:0]  m2,
  output logic [3:0]  s1,
  output logic [3:0]  s2,
  output logic [2:0]  entry_pos,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [16:0] time_sec,
  output logic        commit,
  output logic        err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    HELD,
    REL_CNT
  } deb_state_t;

  // Scan timing and frame capture
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [11:0]      samp;
  logic             slot_end;
  logic             frame_end;
  logic [15:0]      frame;

  // Frame classification
  logic [4:0]       hit_cnt;
  logic [3:0]       hit_idx;
  logic             frame_idle;
  logic             frame_single;
  logic [3:0]       frame_key;

  // Debounce FSM
  deb_state_t       state;
  deb_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       pend_key;
  logic [3:0]       pend_nx;
  logic             accept;

  // Entry buffer and validation
  logic             en_d;
  logic             en_rise;
  logic [3:0]       dig [6];
  logic [2:0]       pos_dec;
  logic [7:0]       hours;
  logic [7:0]       mins;
  logic [7:0]       secs;
  logic             digits_ok;
  logic             time_ok;
  logic [16:0]      time_calc;

  // Keypad position (col*4 + row) to key code.
  function automatic logic [3:0] key_of(input logic [3:0] idx);
    logic [3:0] k;
    k = 4'h0;
    case (idx)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h4;
      4'd2:  k = 4'h7;
      4'd3:  k = 4'hE;
      4'd4:  k = 4'h2;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h8;
      4'd7:  k = 4'h0;
      4'd8:  k = 4'h3;
      4'd9:  k = 4'h6;
      4'd10: k = 4'h9;
      4'd11: k = 4'hF;
      4'd12: k = 4'hA;
      4'd13: k = 4'hB;
      4'd14: k = 4'hC;
      4'd15: k = 4'hD;
    endcase
    return k;
  endfunction

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);
  assign frame     = {~row, samp};

  // Free-running slot divider; on the last clock of each slot, capture the rows and move to the next column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      col_idx <= 2'd0;
      samp    <= '0;
    end else if (slot_end) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
      case (col_idx)
        2'd0:    samp[3:0]  <= ~row;
        2'd1:    samp[7:4]  <= ~row;
        2'd2:    samp[11:8] <= ~row;
        default: ;
      endcase
    end else begin
      div <= div + 1'b1;
    end
  end

  // Count active positions in the frame and remember where the (last) one was.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign frame_idle   = (hit_cnt == 5'd0);
  assign frame_single = (hit_cnt == 5'd1);
  assign frame_key    = key_of(hit_idx);
  assign cnt_inc      = cnt + 1'b1;

  // Debounce state register plus the registered key event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_key  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_key  <= pend_nx;
      key_valid <= accept;
      if (accept) begin
        key_code <= pend_nx;
      end
    end
  end

  // Debounce transitions, evaluated only when a full frame has just been captured.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend_key;
    accept   = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_single) begin
            pend_nx = frame_key;
            if (CNT_ONE >= CNT_DONE) begin
              state_nx = HELD;
              cnt_nx   = '0;
              accept   = 1'b1;
            end else begin
              state_nx = PRESS_CNT;
              cnt_nx   = CNT_ONE;
            end
          end
        end
        PRESS_CNT: begin
          if (frame_single && (frame_key == pend_key)) begin
            if (cnt_inc >= CNT_DONE) begin
              state_nx = HELD;
              cnt_nx   = '0;
              accept   = 1'b1;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        HELD: begin
          if (frame_idle) begin
            if (CNT_ONE >= CNT_DONE) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = REL_CNT;
              cnt_nx   = CNT_ONE;
            end
          end
        end
        REL_CNT: begin
          if (frame_idle) begin
            if (cnt_inc >= CNT_DONE) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = HELD;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Check the buffer as an HH:MM:SS time and precompute its seconds value.
  always_comb begin
    hours     = 8'(dig[0]) * 8'd10 + 8'(dig[1]);
    mins      = 8'(dig[2]) * 8'd10 + 8'(dig[3]);
    secs      = 8'(dig[4]) * 8'd10 + 8'(dig[5]);
    digits_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (dig[i] > 4'd9) begin
        digits_ok = 1'b0;
      end
    end
    time_ok   = digits_ok && (hours <= 8'd23) && (mins <= 8'd59) && (secs <= 8'd59);
    time_calc = 17'(hours) * 17'd3600 + 17'(mins) * 17'd60 + 17'(secs);
  end

  assign en_rise = en & ~en_d;
  assign pos_dec = entry_pos - 3'd1;

  // Entry buffer edits and commit/error pulses, acting on the cycle key_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        dig[i] <= 4'd0;
      end
      entry_pos <= 3'd0;
      en_d      <= 1'b0;
      time_sec  <= '0;
      commit    <= 1'b0;
      err       <= 1'b0;
    end else begin
      en_d   <= en;
      commit <= 1'b0;
      err    <= 1'b0;
      if (en_rise) begin
        for (int i = 0; i < 6; i++) begin
          dig[i] <= 4'd0;
        end
        entry_pos <= 3'd0;
      end else if (key_valid && en) begin
        if (key_code <= 4'd9) begin
          if (entry_pos < 3'd6) begin
            for (int i = 0; i < 6; i++) begin
              if (entry_pos == 3'(i)) begin
                dig[i] <= key_code;
              end
            end
            entry_pos <= entry_pos + 3'd1;
          end
        end else if (key_code == KEY_STAR) begin
          if (entry_pos != 3'd0) begin
            for (int i = 0; i < 6; i++) begin
              if (pos_dec == 3'(i)) begin
                dig[i] <= 4'd0;
              end
            end
            entry_pos <= pos_dec;
          end
        end else if (key_code == KEY_A) begin
          for (int i = 0; i < 6; i++) begin
            dig[i] <= 4'd0;
          end
          entry_pos <= 3'd0;
        end else if (key_code == KEY_HASH) begin
          if (time_ok) begin
            time_sec <= time_calc;
            commit   <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  assign h1 = dig[0];
  assign h2 = dig[1];
  assign m1 = dig[2];
  assign m2 = dig[3];
  assign s1 = dig[4];
  assign s2 = dig[5];

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry: drives a modelled keypad matrix frame by frame and
// compares the entry buffer against a key-level behavioural model.
module tb_keypad_time_entry;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_SCANS  = 2;
  localparam int FRAME_CLKS = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  h1, h2, m1, m2, s1, s2;
  logic [2:0]  entry_pos;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [16:0] time_sec;
  logic        commit;
  logic        err;

  keypad_time_entry #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_SCANS(DEB_SCANS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .row      (row),
    .col      (col),
    .h1       (h1),
    .h2       (h2),
    .m1       (m1),
    .m2       (m2),
    .s1       (s1),
    .s2       (s2),
    .entry_pos(entry_pos),
    .key_valid(key_valid),
    .key_code (key_code),
    .time_sec (time_sec),
    .commit   (commit),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Physical keypad layout, keymap[row][col]
  logic [3:0] keymap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // One bit per key code currently held down
  logic [15:0] pressed;

  // A held key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col[c] == 1'b0 && pressed[keymap[r][c]]) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   obs_kv = 0, obs_commit = 0, obs_err = 0;
  logic kv_prev = 1'b0;

  int         m_dig [6];
  int         m_pos;
  int         m_time;
  logic [3:0] m_kc;
  int         m_kv, m_commit, m_err;
  bit         m_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count pulses; commit/err must follow key_valid by one cycle and never coincide
  always @(negedge clk) begin
    if (key_valid === 1'b1) obs_kv++;
    if (commit === 1'b1) obs_commit++;
    if (err === 1'b1) obs_err++;
    if (commit === 1'b1 || err === 1'b1) begin
      chk("pulse_after_kv", 32'(kv_prev), 32'd1);
      chk("commit_err_excl", 32'(commit & err), 32'd0);
    end
    kv_prev = key_valid;
  end

  function automatic logic [15:0] one_key(input logic [3:0] k);
    return 16'd1 << k;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_dig[i] = 0;
    m_pos = 0;
  endtask

  task automatic model_event(input logic [3:0] k);
    int h, m, s;
    m_kv++;
    m_kc = k;
    if (m_en) begin
      if (k <= 4'd9) begin
        if (m_pos < 6) begin
          m_dig[m_pos] = int'(k);
          m_pos++;
        end
      end else if (k == 4'hE) begin
        if (m_pos > 0) begin
          m_pos--;
          m_dig[m_pos] = 0;
        end
      end else if (k == 4'hA) begin
        model_clear();
      end else if (k == 4'hF) begin
        h = m_dig[0] * 10 + m_dig[1];
        m = m_dig[2] * 10 + m_dig[3];
        s = m_dig[4] * 10 + m_dig[5];
        if (h <= 23 && m <= 59 && s <= 59) begin
          m_time = h * 3600 + m * 60 + s;
          m_commit++;
        end else begin
          m_err++;
        end
      end
    end
  endtask

  task automatic set_en(input bit v);
    if (v && !m_en) model_clear();
    m_en = v;
    en   = v;
  endtask

  task automatic run_frames(input logic [15:0] keys, input int n);
    pressed = keys;
    repeat (n * FRAME_CLKS) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int bounce, input int hold);
    for (int b = 0; b < bounce; b++) begin
      run_frames(one_key(k), 1);
      run_frames(16'h0, 1);
    end
    run_frames(one_key(k), hold);
    run_frames(16'h0, 2);
    if (hold >= DEB_SCANS) model_event(k);
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] d [6];
    d = '{h1, h2, m1, m2, s1, s2};
    for (int i = 0; i < 6; i++) chk($sformatf("%s_d%0d", tag, i), 32'(d[i]), 32'(m_dig[i]));
    chk({tag, "_pos"}, 32'(entry_pos), 32'(m_pos));
    chk({tag, "_code"}, 32'(key_code), 32'(m_kc));
    chk({tag, "_time"}, 32'(time_sec), 32'(m_time));
    chk({tag, "_nkv"}, 32'(obs_kv), 32'(m_kv));
    chk({tag, "_ncommit"}, 32'(obs_commit), 32'(m_commit));
    chk({tag, "_nerr"}, 32'(obs_err), 32'(m_err));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_col"}, 32'(col), 32'h0000000E);
    chk({tag, "_digits"}, 32'({h1, h2, m1, m2, s1, s2}), 32'd0);
    chk({tag, "_pos"}, 32'(entry_pos), 32'd0);
    chk({tag, "_code"}, 32'(key_code), 32'd0);
    chk({tag, "_kv"}, 32'(key_valid), 32'd0);
    chk({tag, "_time"}, 32'(time_sec), 32'd0);
    chk({tag, "_commit"}, 32'(commit), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [3:0] seq_a [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
    logic [3:0] seq_b [7] = '{4'h2, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] rk;

    pressed  = 16'h0;
    en       = 1'b0;
    m_en     = 1'b0;
    m_time   = 0;
    m_kc     = 4'h0;
    m_kv     = 0;
    m_commit = 0;
    m_err    = 0;
    model_clear();

    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    set_en(1'b1);
    run_frames(16'h0, 2);

    $display("[TB] full entry 12:34:56 then #");
    for (int i = 0; i < 7; i++) applyStimulus(seq_a[i], 0, 3);
    checkOutput("valid_commit");
    chk("time_45296", 32'(time_sec), 32'd45296);

    applyStimulus(4'h7, 0, 3);
    checkOutput("full_ignore");

    $display("[TB] invalid 25:00:00");
    applyStimulus(4'hA, 0, 3);
    for (int i = 0; i < 7; i++) applyStimulus(seq_b[i], 0, 3);
    checkOutput("invalid");

    $display("[TB] backspace");
    applyStimulus(4'hA, 0, 3);
    applyStimulus(4'h1, 0, 3);
    applyStimulus(4'h2, 0, 3);
    applyStimulus(4'hE, 0, 3);
    checkOutput("star");
    applyStimulus(4'hE, 0, 2);
    applyStimulus(4'hE, 0, 2);
    checkOutput("star_at_zero");

    $display("[TB] partial commit");
    applyStimulus(4'h1, 0, 2);
    applyStimulus(4'hB, 0, 2);
    applyStimulus(4'hF, 0, 2);
    checkOutput("partial");

    $display("[TB] bounce and multi-key");
    applyStimulus(4'hA, 0, 2);
    applyStimulus(4'h7, 4, 2);
    checkOutput("bounce7");
    run_frames(one_key(4'h3) | one_key(4'h6), 3);
    run_frames(16'h0, 2);
    checkOutput("multi");

    $display("[TB] randomized presses");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) set_en(!m_en);
      if ($urandom_range(0, 9) < 7) rk = 4'($urandom_range(0, 9));
      else rk = 4'($urandom_range(10, 15));
      applyStimulus(rk, int'($urandom_range(0, 2)), int'($urandom_range(2, 4)));
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("[TB] disabled entry and reset during press");
    set_en(1'b1);
    run_frames(16'h0, 1);
    applyStimulus(4'h3, 0, 2);
    set_en(1'b0);
    applyStimulus(4'h9, 0, 3);
    checkOutput("en0_key9");

    run_frames(one_key(4'h4), 1);
    repeat (FRAME_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    m_time = 0;
    m_kc   = 4'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset("reset_mid");
    rst = 1'b1;
    run_frames(one_key(4'h4), 1);
    run_frames(16'h0, 2);
    checkOutput("post_rst_one_frame");
    applyStimulus(4'h4, 0, 2);
    checkOutput("post_rst_press");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry.md
KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per column slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEB_SCANS, default 5, consecutive full 4-column scans needed to accept a press or release.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  entry enable; key events act on the buffer only while high.
REQ-006 SHALL have port row  input  4  keypad rows, active-low, externally pulled up.
REQ-007 SHALL have port col  output  4  keypad column drive, one-hot active-low.
REQ-008 SHALL have ports h1,h2,m1,m2,s1,s2  output  4 each  entry-buffer BCD digits, hours-tens first.
REQ-009 SHALL have port entry_pos  output  3  next digit position, 0 (h1) to 6 (buffer full).
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse per accepted press.
REQ-011 SHALL have port key_code  output  4  code of the last accepted key.
REQ-012 SHALL have port time_sec  output  17  committed time in seconds.
REQ-013 SHALL have port commit  output  1  one-cycle pulse on a valid commit.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an invalid commit.

Function
REQ-015 Scan: a free-running divider SHALL advance col every SCAN_DIV clocks in the order 1110, 1101, 1011, 0111, then wrap. Scanning SHALL run regardless of en.
REQ-016 row SHALL be sampled in the last clk of each column slot. A frame is the set of 4 samples ending at the 0111 slot.
REQ-017 Keymap as (row, col) to key_code: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
REQ-018 Frame classification: exactly one low bit across the frame gives key K; zero low bits gives idle; two or more gives multi.
REQ-019 Debounce FSM states: IDLE, PRESS_CNT, HELD, REL_CNT.
- IDLE: a key-K frame goes to PRESS_CNT with cnt=1.
- PRESS_CNT: each same-K frame increments cnt; at cnt=DEB_SCANS go to HELD and emit the event. A different-key, idle or multi frame returns to IDLE.
- HELD: an idle frame goes to REL_CNT with cnt=1. Other frames stay in HELD.
- REL_CNT: each idle frame increments cnt; at cnt=DEB_SCANS go to IDLE. Any non-idle frame returns to HELD.
REQ-020 Event: key_valid SHALL be high for exactly one clk, the cycle after the accepting frame ends. key_code SHALL update on the same cycle and hold until the next event. There is one event per press, with no auto-repeat.
REQ-021 A rising edge of en SHALL clear all digits to 0 and entry_pos to 0. Events while en=0 SHALL update key_code and key_valid only.
REQ-022 Buffer actions, registered and visible the cycle after key_valid:
- digit 0-9 with entry_pos<6: write the digit at entry_pos, then entry_pos+1. With entry_pos=6: ignored.
- E (*): with entry_pos>0, entry_pos-1 and that digit cleared to 0. With entry_pos=0: no-op.
- A: clear all digits, entry_pos=0.
- B, C, D: ignored.
- F (#): validate (REQ-023); buffer unchanged.
REQ-023 Validate: hours=10*h1+h2 must be <=23, minutes=10*m1+m2 <=59, seconds=10*s1+s2 <=59, and every digit <=9.
- Valid: time_sec = hours*3600 + minutes*60 + seconds (max 86399, fits 17 bits), and commit pulses the cycle after key_valid.
- Invalid: err pulses the same cycle; time_sec holds.
REQ-024 commit and err SHALL never be high together. time_sec SHALL change only on commit.
REQ-025 A commit with entry_pos<6 SHALL use the current digits; unentered digits are 0.

Reset
REQ-026 rst low SHALL asynchronously force:
- col=1110, divider=0, FSM=IDLE, cnt=0;
- all digits=0, entry_pos=0, key_code=0, key_valid=0;
- time_sec=0, commit=0, err=0.
REQ-027 A release of rst SHALL restart scanning from 1110. Reset during a press SHALL discard it, and the press SHALL be accepted only after DEB_SCANS fresh frames.

Verification (SCAN_DIV=4, DEB_SCANS=2)
REQ-028 en rising edge, then keys 1,2,3,4,5,6,# each held 3 frames with idle between -> digits 1,2,3,4,5,6; entry_pos=6; commit pulses once; time_sec=45296.
REQ-029 keys 2,5,0,0,0,0,# -> err pulses once, commit stays 0, time_sec unchanged.
REQ-030 keys 1,2,* -> h1=1, h2=0, entry_pos=1; * at entry_pos=0 leaves state unchanged.
REQ-031 key 7 bouncing (1 frame on, 1 frame off) x4, then held 2 frames -> exactly one key_valid, key_code=7. Keys 3 and 6 held together -> no event.
REQ-032 en=0 and key 9 pressed -> key_valid pulses, key_code=9, digits unchanged. Then assert rst while key 4 is held for 1 frame -> all outputs at reset values, no event until 2 frames after rst release.
